wb_write_queue: RTL and testbench

- Write-side front end for the 16x32 register file.
- Collects results from two producers and serialises them onto the register file's single write port (writeBackEn/destWB/resultWB), in program order:
  - single-cycle ALU/writeback path
  - multi-cycle memory-load response path
- Also reports pending-write hazards on the two read addresses, so the hazard unit stalls decode until the value has reached the file.

---
 rtl/wb_write_queue_pkg.sv | 16 +
 rtl/wb_queue_mem.sv | 42 ++++
 rtl/wb_write_queue.sv | 115 +++++++++++
 tb/tb_wb_write_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/wb_write_queue_pkg.sv
// Shared types and constants for the register-file write-back queue.
package wb_write_queue_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [1:0] push_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/wb_queue_mem.sv
// Entry storage for the write-back queue: two write ports, one async read port,
// plus a snoop of every stored destination for hazard comparison.
module wb_queue_mem
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            we0,
    input  logic [PW-1:0]                   waddr0,
    input  wb_entry_t                       wdata0,
    input  logic                            we1,
    input  logic [PW-1:0]                   waddr1,
    input  wb_entry_t                       wdata1,
    input  logic [PW-1:0]                   raddr,
    output wb_entry_t                       rdata,
    output logic [DEPTH-1:0][WB_ADDR_W-1:0] dests
);

    wb_entry_t mem_q [DEPTH];
    wb_entry_t mem_d [DEPTH];

    // Next storage image; port 1 carries the younger entry
    always_comb begin
        mem_d = mem_q;
        mem_d[waddr0] = we0 ? wdata0 : mem_q[waddr0];
        mem_d[waddr1] = we1 ? wdata1 : mem_d[waddr1];
    end

    // Storage update, deliberately without reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_dest
        assign dests[i] = mem_q[i].dest;
    end

endmodule

// File: rtl/wb_write_queue.sv
// Serialises ALU and load results onto the single register-file write port in
// program order, and flags reads of registers that still have a queued write.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_wb_en,
    input  logic [ADDR_W-1:0]          alu_dest,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       mem_rsp_valid,
    input  logic [ADDR_W-1:0]          mem_dest,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic [ADDR_W-1:0]          src1,
    input  logic [ADDR_W-1:0]          src2,
    output logic                       full,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       hazard1,
    output logic                       hazard2,
    output logic                       writeBackEn,
    output logic [ADDR_W-1:0]          destWB,
    output logic [DATA_W-1:0]          resultWB
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, overflow_q, overflow_d, wb_en_q, wb_en_d;

    logic [1:0]    n_push_s;
    logic          accept_s, pop_s, we0_s, we1_s;
    wb_entry_t     alu_entry_s, mem_entry_s, wdata0_s, head_s;
    logic [DEPTH-1:0][WB_ADDR_W-1:0] dests_s;

    assign alu_entry_s = '{dest: alu_dest, data: alu_result};
    assign mem_entry_s = '{dest: mem_dest, data: mem_rdata};

    // Push/pop bookkeeping; when full every push of the cycle is dropped
    always_comb begin
        n_push_s   = push_count(mem_rsp_valid, alu_wb_en);
        accept_s   = ~full_q;
        pop_s      = (count_q != {CW{1'b0}});
        we0_s      = accept_s && (n_push_s != 2'd0);
        we1_s      = accept_s && (n_push_s == 2'd2);
        wdata0_s   = mem_rsp_valid ? mem_entry_s : alu_entry_s;
        wr_ptr_d   = accept_s ? (wr_ptr_q + PW'(n_push_s)) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
        count_d    = count_q + (accept_s ? CW'(n_push_s) : {CW{1'b0}}) - CW'(pop_s);
        full_d     = (count_d >= CW'(DEPTH-1));
        overflow_d = overflow_q | (full_q & (n_push_s != 2'd0));
        wb_en_d    = (count_d != {CW{1'b0}});
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            wb_en_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            wb_en_q    <= wb_en_d;
        end
    end

    wb_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .we0    (we0_s),
        .waddr0 (wr_ptr_q),
        .wdata0 (wdata0_s),
        .we1    (we1_s),
        .waddr1 (wr_ptr_q + PW'(1'b1)),
        .wdata1 (alu_entry_s),
        .raddr  (rd_ptr_q),
        .rdata  (head_s),
        .dests  (dests_s)
    );

    // Hazard compare over live slots: offset from head below count
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(PW'(i) - rd_ptr_q) < count_q) begin
                hazard1 = hazard1 | (dests_s[i] == src1);
                hazard2 = hazard2 | (dests_s[i] == src2);
            end else begin
                hazard1 = hazard1;
                hazard2 = hazard2;
            end
        end
    end

    assign full        = full_q;
    assign overflow    = overflow_q;
    assign count       = count_q;
    assign writeBackEn = wb_en_q;
    assign destWB      = wb_en_q ? head_s.dest : {ADDR_W{1'b0}};
    assign resultWB    = wb_en_q ? head_s.data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4).
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_wb_en = 1'b0, mem_rsp_valid = 1'b0;
    logic [3:0]  alu_dest = 4'd0, mem_dest = 4'd0, src1 = 4'd0, src2 = 4'd0;
    logic [31:0] alu_result = 32'd0, mem_rdata = 32'd0;
    logic        full, overflow, hazard1, hazard2, writeBackEn;
    logic [2:0]  count;
    logic [3:0]  destWB;
    logic [31:0] resultWB;

    int total = 0;
    int bad = 0;
    logic [31:0] rf [16];

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_wb_en(alu_wb_en), .alu_dest(alu_dest), .alu_result(alu_result),
        .mem_rsp_valid(mem_rsp_valid), .mem_dest(mem_dest), .mem_rdata(mem_rdata),
        .src1(src1), .src2(src2),
        .full(full), .overflow(overflow), .count(count),
        .hazard1(hazard1), .hazard2(hazard2),
        .writeBackEn(writeBackEn), .destWB(destWB), .resultWB(resultWB)
    );

    // Advance one cycle, sample at falling edge, commit the write like the file does
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (writeBackEn) rf[destWB] = resultWB;
    endtask

    task automatic idle_inputs();
        alu_wb_en = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (writeBackEn !== 1'b0) begin bad++; $display("FAIL reset_wben got=%0b exp=0", writeBackEn); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if ({full, overflow, hazard1, hazard2} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {full, overflow, hazard1, hazard2}); end
        total++; if ({destWB, resultWB} !== 36'd0) begin bad++; $display("FAIL reset_wbdata got=%h exp=0", {destWB, resultWB}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu_single();
        alu_wb_en = 1'b1; alu_dest = 4'd3; alu_result = 32'hDEADBEEF;
        step();
        idle_inputs();
        total++; if (writeBackEn !== 1'b1) begin bad++; $display("FAIL alu_wben got=%0b exp=1", writeBackEn); end
        total++; if (destWB !== 4'd3) begin bad++; $display("FAIL alu_dest got=%0d exp=3", destWB); end
        total++; if (resultWB !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_result got=%h exp=deadbeef", resultWB); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL alu_count1 got=%0d exp=1", count); end
        step();
        total++; if (writeBackEn !== 1'b0) begin bad++; $display("FAIL alu_drain_wben got=%0b exp=0", writeBackEn); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL alu_drain_count got=%0d exp=0", count); end
        total++; if (rf[3] !== 32'hDEADBEEF) begin bad++; $display("FAIL alu_rf3 got=%h exp=deadbeef", rf[3]); end
    endtask

    task automatic test_dual_same_dest();
        src1 = 4'd5;
        mem_rsp_valid = 1'b1; mem_dest = 4'd5; mem_rdata = 32'd1;
        alu_wb_en = 1'b1; alu_dest = 4'd5; alu_result = 32'd2;
        step();
        idle_inputs();
        total++; if ({writeBackEn, destWB, resultWB} !== {1'b1, 4'd5, 32'd1}) begin bad++; $display("FAIL dual_first got=%b/%0d/%0d exp=1/5/1", writeBackEn, destWB, resultWB); end
        total++; if (count !== 3'd2) begin bad++; $display("FAIL dual_count got=%0d exp=2", count); end
        total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL dual_haz1_a got=%0b exp=1", hazard1); end
        step();
        total++; if ({writeBackEn, destWB, resultWB} !== {1'b1, 4'd5, 32'd2}) begin bad++; $display("FAIL dual_second got=%b/%0d/%0d exp=1/5/2", writeBackEn, destWB, resultWB); end
        total++; if (hazard1 !== 1'b1) begin bad++; $display("FAIL dual_haz1_b got=%0b exp=1", hazard1); end
        step();
        total++; if (hazard1 !== 1'b0) begin bad++; $display("FAIL dual_haz1_c got=%0b exp=0", hazard1); end
        total++; if (writeBackEn !== 1'b0) begin bad++; $display("FAIL dual_done_wben got=%0b exp=0", writeBackEn); end
        total++; if (rf[5] !== 32'd2) begin bad++; $display("FAIL dual_rf5 got=%0d exp=2", rf[5]); end
        src1 = 4'd0;
    endtask

    task automatic test_full_overflow();
        mem_rsp_valid = 1'b1; mem_dest = 4'd1; mem_rdata = 32'hA1;
        alu_wb_en = 1'b1;     alu_dest = 4'd2; alu_result = 32'hA2;
        step();
        total++; if ({count, full, resultWB} !== {3'd2, 1'b0, 32'hA1}) begin bad++; $display("FAIL full_a got=%0d/%0b/%h exp=2/0/a1", count, full, resultWB); end
        mem_dest = 4'd3; mem_rdata = 32'hB1; alu_dest = 4'd4; alu_result = 32'hB2;
        step();
        total++; if ({count, full, overflow, resultWB} !== {3'd3, 1'b1, 1'b0, 32'hA2}) begin bad++; $display("FAIL full_b got=%0d/%0b/%0b/%h exp=3/1/0/a2", count, full, overflow, resultWB); end
        mem_dest = 4'd5; mem_rdata = 32'hC1; alu_dest = 4'd6; alu_result = 32'hC2;
        step();
        idle_inputs();
        total++; if ({count, full, overflow, resultWB} !== {3'd2, 1'b0, 1'b1, 32'hB1}) begin bad++; $display("FAIL full_c got=%0d/%0b/%0b/%h exp=2/0/1/b1", count, full, overflow, resultWB); end
        step();
        total++; if ({count, destWB, resultWB} !== {3'd1, 4'd4, 32'hB2}) begin bad++; $display("FAIL full_d got=%0d/%0d/%h exp=1/4/b2", count, destWB, resultWB); end
        step();
        total++; if ({count, writeBackEn, overflow} !== {3'd0, 1'b0, 1'b1}) begin bad++; $display("FAIL full_e got=%0d/%0b/%0b exp=0/0/1", count, writeBackEn, overflow); end
    endtask

    task automatic test_hazard2();
        src2 = 4'd7;
        #1;
        total++; if (hazard2 !== 1'b0) begin bad++; $display("FAIL haz2_empty got=%0b exp=0", hazard2); end
        alu_wb_en = 1'b1; alu_dest = 4'd8; alu_result = 32'h8;
        step();
        total++; if (hazard2 !== 1'b0) begin bad++; $display("FAIL haz2_other got=%0b exp=0", hazard2); end
        alu_dest = 4'd7; alu_result = 32'h7;
        step();
        idle_inputs();
        total++; if (hazard2 !== 1'b1) begin bad++; $display("FAIL haz2_set got=%0b exp=1", hazard2); end
        step();
        total++; if (hazard2 !== 1'b0) begin bad++; $display("FAIL haz2_clear got=%0b exp=0", hazard2); end
        src2 = 4'd0;
    endtask

    task automatic test_wrap();
        int errs = 0;
        for (int v = 0; v < 20; v++) begin
            logic [31:0] val;
            val = v;
            alu_wb_en = 1'b1; alu_dest = val[3:0]; alu_result = val;
            step();
            idle_inputs();
            total++;
            if ({writeBackEn, resultWB} !== {1'b1, val}) begin
                bad++; errs++;
                $display("FAIL wrap_val got=%b/%0d exp=1/%0d", writeBackEn, resultWB, v);
            end
            step();
            total++;
            if (writeBackEn !== 1'b0) begin
                bad++; errs++;
                $display("FAIL wrap_idle got=%0b exp=0 at v=%0d", writeBackEn, v);
            end
        end
    endtask

    task automatic test_reset_mid();
        src1 = 4'd10;
        mem_rsp_valid = 1'b1; mem_dest = 4'd10; mem_rdata = 32'h100;
        alu_wb_en = 1'b1;     alu_dest = 4'd11; alu_result = 32'h101;
        step();
        idle_inputs();
        total++; if ({count, resultWB} !== {3'd2, 32'h100}) begin bad++; $display("FAIL rmid_pre got=%0d/%h exp=2/100", count, resultWB); end
        #2 rst = 1'b0;
        #1;
        total++; if ({writeBackEn, destWB, resultWB} !== 37'd0) begin bad++; $display("FAIL rmid_wb got=%h exp=0", {writeBackEn, destWB, resultWB}); end
        total++; if ({count, overflow, full, hazard1} !== 6'd0) begin bad++; $display("FAIL rmid_state got=%b exp=0", {count, overflow, full, hazard1}); end
        @(negedge clk);
        rst = 1'b1;
        alu_wb_en = 1'b1; alu_dest = 4'd9; alu_result = 32'd55;
        step();
        idle_inputs();
        total++; if ({writeBackEn, destWB, resultWB, count} !== {1'b1, 4'd9, 32'd55, 3'd1}) begin bad++; $display("FAIL rmid_push got=%b/%0d/%0d/%0d exp=1/9/55/1", writeBackEn, destWB, resultWB, count); end
        step();
        total++; if ({writeBackEn, count} !== {1'b0, 3'd0}) begin bad++; $display("FAIL rmid_drain got=%b/%0d exp=0/0", writeBackEn, count); end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = 32'd0;
        test_reset();
        test_alu_single();
        test_dual_same_dest();
        test_full_overflow();
        test_hazard2();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
